// File: rtl/hilo_ctrl_if.sv
// hilo_ctrl_if: EX-side op handshake and HI/LO read-out bundle for hilo_ctrl
interface hilo_ctrl_if;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        op_ready;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output op_valid, op_code, op_a, op_b, flush, input op_ready, busy, hi, lo);
    modport slave (input op_valid, op_code, op_a, op_b, flush, output op_ready, busy, hi, lo);
endinterface

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: EX-stage HI/LO unit (1-cycle multiply, iterative-divider sequencing, flush drain); HILO_DIVZERO_FAST_EN retires zero-divisor divides in one cycle
module hilo_ctrl (
    input  logic        clk,
    input  logic        reset,
    hilo_ctrl_if.slave  bus,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_x,
    output logic [31:0] div_y,
    input  logic [63:0] div_result,
    input  logic        div_complete
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    typedef enum logic [1:0] {IDLE, DIV_WAIT, DIV_DRAIN} state_t;
    state_t      state, state_nxt;
    logic [31:0] hi_q, lo_q, hi_nxt, lo_nxt;
    logic [31:0] x_q, y_q;
    logic        sgn_q;
    logic        go, is_div, divzero;
    logic [63:0] prod_s, prod_u;
    assign go     = bus.op_valid && !bus.flush;
    assign is_div = bus.op_code == OP_DIV || bus.op_code == OP_DIVU;
`ifdef HILO_DIVZERO_FAST_EN
    assign divzero = bus.op_b == 32'd0;
`else
    assign divzero = 1'b0;
`endif
    assign prod_s   = {{32{bus.op_a[31]}}, bus.op_a} * {{32{bus.op_b[31]}}, bus.op_b};
    assign prod_u   = {32'd0, bus.op_a} * {32'd0, bus.op_b};
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = state != IDLE;
    // Next state, handshake, divider drive and HI/LO next values
    always_comb begin
        state_nxt    = state;
        bus.op_ready = 1'b0;
        div_start    = 1'b0;
        div_x        = x_q;
        div_y        = y_q;
        div_signed   = sgn_q;
        hi_nxt       = hi_q;
        lo_nxt       = lo_q;
        case (state)
            IDLE: if (go) begin
                if (is_div && !divzero) begin
                    div_start  = 1'b1;
                    div_x      = bus.op_a;
                    div_y      = bus.op_b;
                    div_signed = bus.op_code == OP_DIV;
                    state_nxt  = DIV_WAIT;
                end else begin
                    bus.op_ready = 1'b1;
                    case (bus.op_code)
                        OP_MULT:          {hi_nxt, lo_nxt} = prod_s;
                        OP_MULTU:         {hi_nxt, lo_nxt} = prod_u;
                        OP_MTHI:          hi_nxt = bus.op_a;
                        OP_MTLO:          lo_nxt = bus.op_a;
                        OP_DIV, OP_DIVU:  {hi_nxt, lo_nxt} = {bus.op_a, 32'hFFFF_FFFF};
                        default:          ;
                    endcase
                end
            end
            DIV_WAIT: if (bus.flush) begin
                state_nxt = div_complete ? IDLE : DIV_DRAIN;
            end else if (div_complete) begin
                bus.op_ready = 1'b1;
                lo_nxt       = div_result[63:32];
                hi_nxt       = div_result[31:0];
                state_nxt    = IDLE;
            end
            DIV_DRAIN: state_nxt = div_complete ? IDLE : DIV_DRAIN;
            default: state_nxt = IDLE;
        endcase
    end
    // State, HI/LO and latched divider operands
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            x_q   <= 32'd0;
            y_q   <= 32'd0;
            sgn_q <= 1'b0;
        end else begin
            state <= state_nxt;
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            if (div_start) begin
                x_q   <= div_x;
                y_q   <= div_y;
                sgn_q <= div_signed;
            end
        end
    end
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: scoreboard bench for hilo_ctrl with a 33-step divider model
module tb_hilo_ctrl;
    localparam logic [2:0] MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011, DIVU = 3'b100, MTHI = 3'b101, MTLO = 3'b110;
    typedef struct {int cyc; logic [31:0] hi; logic [31:0] lo;} exp_t;
    logic        clk = 0, reset = 1;
    logic        div_start, div_signed, div_complete;
    logic [31:0] div_x, div_y, dx, dy;
    logic [63:0] div_result;
    logic        ds;
    int          dcnt = 0, cyc = 0, starts = 0, last_start = -1, busy_cnt = 0;
    int          pass = 0, total = 0;
    exp_t        q[$];
    hilo_ctrl_if bus();
    hilo_ctrl dut (.clk(clk), .reset(reset), .bus(bus), .div_start(div_start), .div_signed(div_signed),
                   .div_x(div_x), .div_y(div_y), .div_result(div_result), .div_complete(div_complete));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Divider model: complete in the 33rd cycle after the start edge
    always @(posedge clk) begin
        if (reset) dcnt <= 0;
        else if (div_start) begin
            dcnt <= 1;
            dx   <= div_x;
            dy   <= div_y;
            ds   <= div_signed;
        end else if (dcnt == 33) dcnt <= 0;
        else if (dcnt != 0) dcnt <= dcnt + 1;
    end
    assign div_complete = dcnt == 33;
    always_comb begin
        if (dy == 32'd0) div_result = {32'hFFFF_FFFF, dx};
        else if (ds) div_result = {32'($signed(dx) / $signed(dy)), 32'($signed(dx) % $signed(dy))};
        else div_result = {dx / dy, dx % dy};
    end
    // Activity counters sampled mid-cycle
    always @(negedge clk) begin
        if (div_start) begin
            starts     <= starts + 1;
            last_start <= cyc;
        end
        if (bus.busy) busy_cnt <= busy_cnt + 1;
    end
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass++;
    endtask
    // Monitor: every accepted op is checked against the queued expectation
    initial forever begin
        int c;
        exp_t e;
        @(negedge clk);
        if (bus.op_ready) begin
            c = cyc;
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_ready: op_ready at cycle %0d with nothing expected", c);
            end else begin
                e = q.pop_front();
                chk("accept_cycle", 64'(c), 64'(e.cyc));
                chk("hi", {32'd0, bus.hi}, {32'd0, e.hi});
                chk("lo", {32'd0, bus.lo}, {32'd0, e.lo});
            end
        end
    end
    task automatic set_op(input logic v, input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = v;
        bus.op_code  = code;
        bus.op_a     = a;
        bus.op_b     = b;
    endtask
    task automatic present(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b, input int lat, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        e.cyc = cyc + lat;
        e.hi  = eh;
        e.lo  = el;
        q.push_back(e);
        set_op(1'b1, code, a, b);
    endtask
    task automatic wait_acc();
        bit got = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.op_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            total++;
            $display("FAIL accept_timeout: no op_ready within 60 cycles at cycle %0d", cyc);
        end
        @(posedge clk);
        #1;
        set_op(1'b0, 3'b000, 32'd0, 32'd0);
    endtask
    task automatic do_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b, input int lat, input logic [31:0] eh, input logic [31:0] el);
        present(code, a, b, lat, eh, el);
        wait_acc();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int t, s0, b0;
        bus.flush = 0;
        set_op(1'b0, 3'b000, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        chk("rst_hi", {32'd0, bus.hi}, 0);
        chk("rst_lo", {32'd0, bus.lo}, 0);
        chk("rst_ready", {63'd0, bus.op_ready}, 0);
        chk("rst_busy", {63'd0, bus.busy}, 0);
        chk("rst_start", {63'd0, div_start}, 0);
        chk("rst_signed", {63'd0, div_signed}, 0);
        chk("rst_x", {32'd0, div_x}, 0);
        chk("rst_y", {32'd0, div_y}, 0);
        @(posedge clk);
        #1;
        do_op(MULT, 32'hFFFF_FFFF, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op(MULTU, 32'hFFFF_FFFF, 32'd2, 0, 32'h0000_0001, 32'hFFFF_FFFE);
        do_op(MTHI, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, 32'hFFFF_FFFE);
        do_op(MTLO, 32'hCAFE_BABE, 32'd0, 0, 32'h1234_5678, 32'hCAFE_BABE);
        do_op(3'b111, 32'h5555_5555, 32'h7, 0, 32'h1234_5678, 32'hCAFE_BABE);
        t = cyc; s0 = starts; b0 = busy_cnt;
        do_op(DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        chk("divu_starts", 64'(starts - s0), 1);
        chk("divu_start_cyc", 64'(last_start), 64'(t));
        chk("divu_busy_cycles", 64'(busy_cnt - b0), 33);
        do_op(DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        t = cyc;
        set_op(1'b1, DIV, 32'd50, 32'd5);
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1;
        @(posedge clk);
        #1;
        bus.flush = 0;
        chk("drain_busy", {63'd0, bus.busy}, 1);
        present(MTHI, 32'hAAAA_0000, 32'd0, t + 34 - cyc, 32'hAAAA_0000, 32'hFFFF_FFFD);
        wait_acc();
        t = cyc;
        set_op(1'b1, DIV, 32'd20, 32'd3);
        repeat (33) @(posedge clk);
        #1;
        bus.flush = 1;
        @(negedge clk);
        chk("coinc_ready", {63'd0, bus.op_ready}, 0);
        @(posedge clk);
        #1;
        bus.flush = 0;
        chk("coinc_idle", {63'd0, bus.busy}, 0);
        chk("coinc_hi", {32'd0, bus.hi}, 64'h0000_0000_AAAA_0000);
        chk("coinc_lo", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFFD);
        t = cyc; s0 = starts;
        do_op(DIV, 32'd20, 32'd3, 33, 32'd2, 32'd6);
        chk("b2b_start_cyc", 64'(last_start), 64'(t));
        chk("b2b_starts", 64'(starts - s0), 1);
        s0 = starts;
`ifdef HILO_DIVZERO_FAST_EN
        do_op(DIVU, 32'd5, 32'd0, 0, 32'd5, 32'hFFFF_FFFF);
        chk("dz_starts", 64'(starts - s0), 0);
`else
        do_op(DIVU, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF);
        chk("dz_starts", 64'(starts - s0), 1);
`endif
        set_op(1'b1, DIVU, 32'd1000, 32'd10);
        repeat (5) @(posedge clk);
        #1;
        reset = 1;
        set_op(1'b0, 3'b000, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        chk("mid_rst_hi", {32'd0, bus.hi}, 0);
        chk("mid_rst_lo", {32'd0, bus.lo}, 0);
        chk("mid_rst_busy", {63'd0, bus.busy}, 0);
        chk("mid_rst_ready", {63'd0, bus.op_ready}, 0);
        chk("mid_rst_start", {63'd0, div_start}, 0);
        chk("mid_rst_signed", {63'd0, div_signed}, 0);
        chk("mid_rst_x", {32'd0, div_x}, 0);
        chk("mid_rst_y", {32'd0, div_y}, 0);
        @(posedge clk);
        #1;
        do_op(DIVU, 32'd9, 32'd3, 33, 32'd0, 32'd3);
        repeat (3) @(posedge clk);
        chk("pending", 64'(q.size()), 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
